// File: rtl/oven_setpoint_entry.sv
// oven_setpoint_entry: debounces the three front-panel buttons, steps the user
// through temperature / minutes / seconds entry and issues a one-cycle start
// strobe once a non-zero bake time has been entered.
// Optional build macro: OVEN_AUTO_REPEAT_EN (auto-repeat on a held inc button).
module oven_setpoint_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TEMP_MIN        = 150,
  parameter int TEMP_MAX        = 500,
  parameter int TEMP_STEP       = 25,
  parameter int REPEAT_CYCLES   = 15000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_start,
  output logic [8:0] temp_set,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] field,
  output logic       editing,
  output logic       locked,
  output logic       start_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity checks on the configuration
  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || TEMP_STEP < 1 ||
      TEMP_MAX < TEMP_MIN || TEMP_MAX > 511) begin : gen_bad_params
    $error("oven_setpoint_entry: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_TEMP,
    S_EDIT_MIN,
    S_EDIT_SEC,
    S_LOCKED
  } state_t;

  state_t state_reg;

  // Button index: 0 = inc, 1 = next, 2 = start
  logic [2:0] btn_raw;
  logic [2:0] press_evt;

  assign btn_raw = {btn_start, btn_next, btn_inc};

  for (genvar gi = 0; gi < 3; gi++) begin : gen_btn
    logic            sync1_reg;
    logic            sync2_reg;
    logic            level_reg;
    logic            level_d_reg;
    logic            press_reg;
    logic [DB_W-1:0] cnt_reg;

    // Synchronise, debounce (any bounce restarts the count), then pulse on the rising edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        level_reg   <= 1'b0;
        level_d_reg <= 1'b0;
        press_reg   <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        sync1_reg   <= btn_raw[gi];
        sync2_reg   <= sync1_reg;
        level_d_reg <= level_reg;
        press_reg   <= level_reg & ~level_d_reg;
        if (sync2_reg != level_reg) begin
          if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end else begin
          cnt_reg <= '0;
        end
      end
    end

    assign press_evt[gi] = press_reg;
  end

  logic inc_evt;
  logic next_evt;
  logic start_evt;

  assign next_evt  = press_evt[1];
  assign start_evt = press_evt[2];

`ifdef OVEN_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic             inc_level;
  logic             in_edit;
  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             rpt_evt_reg;
  state_t           rpt_state_reg;

  assign inc_level = gen_btn[0].level_reg;
  assign in_edit   = (state_reg == S_EDIT_TEMP) || (state_reg == S_EDIT_MIN) ||
                     (state_reg == S_EDIT_SEC);

  // Repeat timer: restarts at each real press, clears on release, state change or power-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_reg   <= '0;
      rpt_evt_reg   <= 1'b0;
      rpt_state_reg <= S_IDLE;
    end else begin
      rpt_state_reg <= state_reg;
      rpt_evt_reg   <= 1'b0;
      if (!enable || !inc_level || !in_edit || (state_reg != rpt_state_reg)) begin
        rpt_cnt_reg <= '0;
      end else if (press_evt[0]) begin
        rpt_cnt_reg <= '0;
      end else if (rpt_cnt_reg == RPT_LAST) begin
        rpt_cnt_reg <= '0;
        rpt_evt_reg <= 1'b1;
      end else begin
        rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
      end
    end
  end

  assign inc_evt = press_evt[0] | rpt_evt_reg;
`else
  assign inc_evt = press_evt[0];
`endif

  // BCD 00..59 increment with wrap to 00; returns {tens, ones}
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones >= 4'd9) begin
      res[3:0] = 4'd0;
      res[7:4] = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      res[3:0] = ones + 4'd1;
      res[7:4] = tens;
    end
    return res;
  endfunction

  logic [9:0] temp_sum;
  logic [8:0] temp_incd;
  logic [7:0] min_incd;
  logic [7:0] sec_incd;
  logic       time_nonzero;

  assign temp_sum     = {1'b0, temp_set} + 10'(TEMP_STEP);
  assign temp_incd    = (temp_sum > 10'(TEMP_MAX)) ? 9'(TEMP_MIN) : temp_sum[8:0];
  assign min_incd     = bcd_inc(min_tens, min_ones);
  assign sec_incd     = bcd_inc(sec_tens, sec_ones);
  assign time_nonzero = |{min_tens, min_ones, sec_tens, sec_ones};

  // Entry state machine; all outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      temp_set    <= 9'(TEMP_MIN);
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      field       <= 2'd0;
      editing     <= 1'b0;
      locked      <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (!enable) begin
        state_reg <= S_IDLE;
        editing   <= 1'b0;
        locked    <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg <= S_EDIT_TEMP;
            field     <= 2'd0;
            editing   <= 1'b1;
          end
          S_EDIT_TEMP, S_EDIT_MIN, S_EDIT_SEC: begin
            if (start_evt) begin
              // A start with zero time is swallowed; lower-priority presses are dropped too
              if (time_nonzero) begin
                start_pulse <= 1'b1;
                state_reg   <= S_LOCKED;
                editing     <= 1'b0;
                locked      <= 1'b1;
              end
            end else if (next_evt) begin
              case (state_reg)
                S_EDIT_TEMP: begin state_reg <= S_EDIT_MIN;  field <= 2'd1; end
                S_EDIT_MIN:  begin state_reg <= S_EDIT_SEC;  field <= 2'd2; end
                default:     begin state_reg <= S_EDIT_TEMP; field <= 2'd0; end
              endcase
            end else if (inc_evt) begin
              case (state_reg)
                S_EDIT_TEMP: temp_set <= temp_incd;
                S_EDIT_MIN:  {min_tens, min_ones} <= min_incd;
                default:     {sec_tens, sec_ones} <= sec_incd;
              endcase
            end
          end
          S_LOCKED: begin
            state_reg <= S_LOCKED;
          end
          default: begin
            state_reg <= S_IDLE;
            editing   <= 1'b0;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oven_setpoint_entry.sv
// Directed bench for oven_setpoint_entry with short debounce / repeat times.
module tb_oven_setpoint_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_start;
  logic [8:0] temp_set;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] field;
  logic       editing;
  logic       locked;
  logic       start_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  oven_setpoint_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn_inc    (btn_inc),
    .btn_next   (btn_next),
    .btn_start  (btn_start),
    .temp_set   (temp_set),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .field      (field),
    .editing    (editing),
    .locked     (locked),
    .start_pulse(start_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // mask bit0 = inc, bit1 = next, bit2 = start; counts cycles with start_pulse high
  task automatic press(input logic [2:0] mask, input int hold, output int pulses);
    pulses = 0;
    @(negedge clk);
    btn_inc   = mask[0];
    btn_next  = mask[1];
    btn_start = mask[2];
    repeat (hold) begin
      @(negedge clk);
      if (start_pulse) pulses++;
    end
    btn_inc   = 1'b0;
    btn_next  = 1'b0;
    btn_start = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (start_pulse) pulses++;
    end
  endtask

  initial begin
    int p;
    int exp_temp;
    int m;

    rst       = 1'b1;
    enable    = 1'b0;
    btn_inc   = 1'b0;
    btn_next  = 1'b0;
    btn_start = 1'b0;
    #12 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_temp", 32'(temp_set), 150);
    check_eq("rst_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    check_eq("rst_field", 32'(field), 0);
    check_eq("rst_editing", 32'(editing), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_start", 32'(start_pulse), 0);

    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("en_editing", 32'(editing), 1);
    check_eq("en_field", 32'(field), 0);

    // Latency: value must change on the edge DEBOUNCE_CYCLES+4 after the raw edge
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (7) @(negedge clk);
    check_eq("lat_before", 32'(temp_set), 150);
    @(negedge clk);
    check_eq("lat_at", 32'(temp_set), 175);
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);

    // Short glitch must be rejected
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch", 32'(temp_set), 175);

    // Temperature sweep up to 500 and wrap
    exp_temp = 175;
    for (int i = 0; i < 14; i++) begin
      press(3'b001, 10, p);
      exp_temp = (exp_temp + 25 > 500) ? 150 : exp_temp + 25;
      check_eq("temp_seq", 32'(temp_set), 32'(exp_temp));
    end
    check_eq("temp_wrap", 32'(temp_set), 150);

    press(3'b010, 10, p);
    check_eq("field_min", 32'(field), 1);

    // Minutes sweep 01..59 then 00
    for (int i = 1; i <= 60; i++) begin
      press(3'b001, 10, p);
      m = i % 60;
      check_eq("min_tens", 32'(min_tens), 32'(m / 10));
      check_eq("min_ones", 32'(min_ones), 32'(m % 10));
    end
    check_eq("min_temp_kept", 32'(temp_set), 150);

    // Start with 00:00 is ignored
    press(3'b100, 10, p);
    check_eq("start_zero_pulse", 32'(p), 0);
    check_eq("start_zero_edit", 32'(editing), 1);
    check_eq("start_zero_lock", 32'(locked), 0);

    press(3'b010, 10, p);
    check_eq("field_sec", 32'(field), 2);
    for (int i = 0; i < 30; i++) press(3'b001, 10, p);
    check_eq("sec_tens", 32'(sec_tens), 3);
    check_eq("sec_ones", 32'(sec_ones), 0);

    press(3'b100, 10, p);
    check_eq("start_pulse_cnt", 32'(p), 1);
    check_eq("start_locked", 32'(locked), 1);
    check_eq("start_editing", 32'(editing), 0);

    // Locked: presses ignored
    press(3'b001, 10, p);
    press(3'b010, 10, p);
    check_eq("lock_pulses", 32'(p), 0);
    check_eq("lock_temp", 32'(temp_set), 150);
    check_eq("lock_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0030);
    check_eq("lock_field", 32'(field), 2);
    check_eq("lock_locked", 32'(locked), 1);

    // Power cycle: back to IDLE, then EDIT_TEMP with values retained
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("off_locked", 32'(locked), 0);
    check_eq("off_editing", 32'(editing), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("on_editing", 32'(editing), 1);
    check_eq("on_field", 32'(field), 0);
    check_eq("on_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0030);
    check_eq("on_temp", 32'(temp_set), 150);

    // next and inc together: next wins, inc discarded
    press(3'b011, 10, p);
    check_eq("both_field", 32'(field), 1);
    check_eq("both_temp", 32'(temp_set), 150);
    check_eq("both_min", 32'({min_tens, min_ones}), 0);

    press(3'b010, 10, p);
    press(3'b010, 10, p);
    check_eq("back_temp_field", 32'(field), 0);
    exp_temp = 150;

`ifdef OVEN_AUTO_REPEAT_EN
    // Held ~70 cycles after debounce: one press plus three repeats
    press(3'b001, 76, p);
    exp_temp = 250;
    check_eq("repeat_temp", 32'(temp_set), 32'(exp_temp));
`endif

    press(3'b001, 10, p);
    exp_temp = exp_temp + 25;
    check_eq("pre_rst_temp", 32'(temp_set), 32'(exp_temp));

    // Asynchronous reset mid-cycle takes effect without a clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_temp", 32'(temp_set), 150);
    check_eq("arst_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    check_eq("arst_field", 32'(field), 0);
    check_eq("arst_editing", 32'(editing), 0);
    check_eq("arst_start", 32'(start_pulse), 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
